// File: rtl/sweep_pkg.sv
// Shared types and default widths for the frequency-sweep sequencer.
// dir_t exists only when SWEEP_PINGPONG_EN is defined.
package sweep_pkg;

    localparam int SWEEP_WIDTH   = 8;
    localparam int SWEEP_DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

`ifdef SWEEP_PINGPONG_EN
    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;
`endif

endpackage

// File: rtl/sweep_ctrl_if.sv
// Control/config/status bundle between the top-level control and sweep_ctrl.
// master = top-level control side, slave = sweep_ctrl.
interface sweep_ctrl_if
    import sweep_pkg::*;
#(
    parameter int WIDTH   = SWEEP_WIDTH,
    parameter int DWELL_W = SWEEP_DWELL_W
);

    logic               start;
    logic               stop;
    logic               repeat_mode;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_inc;
    logic [DWELL_W-1:0] dwell;
    logic               cnt_en;
    logic [WIDTH-1:0]   incr;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output start, stop, repeat_mode, step_lo, step_hi, step_inc, dwell,
        input  cnt_en, incr, busy, done, wrap
    );

    modport slave (
        input  start, stop, repeat_mode, step_lo, step_hi, step_inc, dwell,
        output cnt_en, incr, busy, done, wrap
    );

endinterface

// File: rtl/dwell_timer.sv
// Counts the cycles a step value is held; expire is high on the last one.
// A dwell of 0 behaves exactly like a dwell of 1.
module dwell_timer
    import sweep_pkg::*;
#(
    parameter int DWELL_W = SWEEP_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               run,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] last;

    assign last   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign expire = run && !load && (cnt_q == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= expire ? '0 : cnt_q + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: ramps the address-counter increment from step_lo
// to step_hi, holding each value for a dwell. SWEEP_PINGPONG_EN adds a down ramp.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH   = SWEEP_WIDTH,
    parameter int DWELL_W = SWEEP_DWELL_W
) (
    input  logic        clk,
    input  logic        rst,
    sweep_ctrl_if.slave bus,
    output state_t      dbg_state
);

    // Handshake: start is a one-cycle request honoured only in IDLE; busy is
    // high while the sweep runs; done pulses once when a one-shot sweep ends
    // (or on an invalid start); stop aborts from any state with no done/wrap.

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   inc_q, inc_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               rep_q, rep_d;
    logic               wrap_flag_q, wrap_flag_d;

    logic               cnt_en_q, cnt_en_d;
    logic [WIDTH-1:0]   incr_q, incr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;

    logic [WIDTH:0]     nxt;
    logic               up_ok;
    logic               expire;
    logic               tmr_load;
    logic               tmr_run;

    // The extra top bit catches overflow past the counter width.
    assign nxt   = {1'b0, cur_q} + {1'b0, inc_q};
    assign up_ok = (nxt <= {1'b0, hi_q});

`ifdef SWEEP_PINGPONG_EN
    dir_t           dir_q, dir_d;
    logic [WIDTH:0] dn;
    logic           dn_ok;

    assign dn    = {1'b0, cur_q} - {1'b0, inc_q};
    assign dn_ok = !dn[WIDTH] && (dn[WIDTH-1:0] >= lo_q);
`endif

    assign tmr_load = (state_q != RUN) || bus.stop;
    assign tmr_run  = (state_q == RUN);

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .dwell  (dwell_q),
        .run    (tmr_run),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        inc_d       = inc_q;
        dwell_d     = dwell_q;
        rep_d       = rep_q;
        wrap_flag_d = 1'b0;
`ifdef SWEEP_PINGPONG_EN
        dir_d       = dir_q;
`endif

        // Outputs show the state one cycle behind the FSM.
        cnt_en_d = (state_q == RUN);
        busy_d   = (state_q == RUN);
        incr_d   = (state_q == RUN) ? cur_q : '0;
        done_d   = (state_q == FIN);
        wrap_d   = (state_q == RUN) && wrap_flag_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    lo_d    = bus.step_lo;
                    hi_d    = bus.step_hi;
                    inc_d   = bus.step_inc;
                    dwell_d = bus.dwell;
                    rep_d   = bus.repeat_mode;
                    cur_d   = bus.step_lo;
`ifdef SWEEP_PINGPONG_EN
                    dir_d   = UP;
`endif
                    state_d = (bus.step_lo > bus.step_hi) ? FIN : RUN;
                end
            end
            RUN: begin
                if (expire) begin
`ifdef SWEEP_PINGPONG_EN
                    if (dir_q == UP && up_ok) begin
                        cur_d = nxt[WIDTH-1:0];
                    end else if (dn_ok) begin
                        dir_d = DOWN;
                        cur_d = dn[WIDTH-1:0];
                    end else if (rep_q) begin
                        dir_d       = UP;
                        wrap_flag_d = 1'b1;
                        cur_d       = up_ok ? nxt[WIDTH-1:0] : cur_q;
                    end else begin
                        state_d = FIN;
                    end
`else
                    if (up_ok) begin
                        cur_d = nxt[WIDTH-1:0];
                    end else if (rep_q) begin
                        cur_d       = lo_q;
                        wrap_flag_d = 1'b1;
                    end else begin
                        state_d = FIN;
                    end
`endif
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.stop) begin
            state_d     = IDLE;
            wrap_flag_d = 1'b0;
            cnt_en_d    = 1'b0;
            busy_d      = 1'b0;
            incr_d      = '0;
            done_d      = 1'b0;
            wrap_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            inc_q       <= '0;
            dwell_q     <= '0;
            rep_q       <= 1'b0;
            wrap_flag_q <= 1'b0;
            cnt_en_q    <= 1'b0;
            incr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            dir_q       <= UP;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            inc_q       <= inc_d;
            dwell_q     <= dwell_d;
            rep_q       <= rep_d;
            wrap_flag_q <= wrap_flag_d;
            cnt_en_q    <= cnt_en_d;
            incr_q      <= incr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
`ifdef SWEEP_PINGPONG_EN
            dir_q       <= dir_d;
`endif
        end
    end

    assign bus.cnt_en = cnt_en_q;
    assign bus.incr   = incr_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.wrap   = wrap_q;
    assign dbg_state  = state_q;

endmodule
